// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results bypass or queue,
// and a starvation FSM requests a WB bubble when a buffered result is blocked too long.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_regwrite,
    input  logic [4:0]               pipe_rd,
    input  logic [31:0]              pipe_result,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [4:0]               lu_rd,
    input  logic [31:0]              lu_result,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     wb_stall_req,
    output logic [$clog2(DEPTH):0]   lu_pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, DRAIN, STARVE} state_e;

    logic [4:0]    rd_mem_q   [DEPTH];
    logic [4:0]    rd_mem_d   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   data_mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          stall_q, stall_d;

    logic pipe_we, empty, full, head_vld, pop, accept, bypass, enq, blocked;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pipe_we  = pipe_regwrite && (pipe_rd != 5'd0);
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        head_vld = !empty && vld_q[rd_ptr_q];
        blocked  = head_vld && pipe_we;
        // A killed head drains regardless of the pipe; a live head only when the port is free.
        pop      = !empty && (!vld_q[rd_ptr_q] || !pipe_we);
        lu_ready = !reset && (!full || pop);
        accept   = lu_valid && lu_ready;
        bypass   = accept && empty && !pipe_we && (lu_rd != 5'd0);
        enq      = accept && (lu_rd != 5'd0) && !bypass && !(pipe_we && (lu_rd == pipe_rd));

        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!reset) begin
            if (pipe_we) begin
                rf_we    = 1'b1;
                rf_waddr = pipe_rd;
                rf_wdata = pipe_result;
            end else if (head_vld) begin
                rf_we    = 1'b1;
                rf_waddr = rd_mem_q[rd_ptr_q];
                rf_wdata = data_mem_q[rd_ptr_q];
            end else if (bypass) begin
                rf_we    = 1'b1;
                rf_waddr = lu_rd;
                rf_wdata = lu_result;
            end
        end

        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        vld_d      = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_we && (rd_mem_q[i] == pipe_rd)) vld_d[i] = 1'b0;
        end
        if (enq) begin
            rd_mem_d[wr_ptr_q]   = lu_rd;
            data_mem_d[wr_ptr_q] = lu_result;
            vld_d[wr_ptr_q]      = 1'b1;
        end
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q + CW'(enq) - CW'(pop);

        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall_d    = stall_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (enq) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop) begin
                    wait_cnt_d = '0;
                    if (count_d == '0) state_d = IDLE;
                end else if (blocked) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q + 1'b1 == WAIT_LIM) begin
                        state_d = STARVE;
                        stall_d = 1'b1;
                    end
                end
            end
            STARVE: begin
                stall_d = 1'b1;
                if (pop) begin
                    wait_cnt_d = '0;
                    stall_d    = 1'b0;
                    state_d    = (count_d == '0) ? IDLE : DRAIN;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
                stall_d    = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

    // NOTE: the payload storage is not reset; the per-entry valid bits and occupancy guard every read.
    always_ff @(posedge clk) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign wb_stall_req = stall_q;
    assign lu_pending   = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, MAX_WAIT=4) with hand-computed expectations.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_regwrite;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_result;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_stall_req;
    logic [1:0]  lu_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_regwrite(pipe_regwrite), .pipe_rd(pipe_rd), .pipe_result(pipe_result),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_result(lu_result),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_stall_req(wb_stall_req), .lu_pending(lu_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pres,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] lres);
        pipe_regwrite = pw; pipe_rd = prd; pipe_result = pres;
        lu_valid = lv; lu_rd = lrd; lu_result = lres;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 5'd5, 32'hA5, 1'b1, 5'd7, 32'h1);
        sample();
        check("reset_rf_we", rf_we, 0);
        check("reset_lu_ready", lu_ready, 0);
        tick();
        check("reset_pending", lu_pending, 0);
        check("reset_stall", wb_stall_req, 0);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        // Pipe-only writes
        drive(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'h0);
        sample();
        check("pipe_we", rf_we, 1);
        check("pipe_waddr", rf_waddr, 5);
        check("pipe_wdata", rf_wdata, 32'hA5);
        tick();
        drive(1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'h0);
        sample();
        check("pipe_rd0_we", rf_we, 0);
        check("pipe_rd0_waddr", rf_waddr, 0);
        tick();

        // Bypass
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
        sample();
        check("byp_we", rf_we, 1);
        check("byp_waddr", rf_waddr, 7);
        check("byp_wdata", rf_wdata, 32'h1234);
        check("byp_ready", lu_ready, 1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        sample();
        check("byp_pending", lu_pending, 0);
        tick();

        // Buffer behind a pipe write, then drain on the idle cycle
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h11);
        sample();
        check("buf_pipe_waddr", rf_waddr, 4);
        check("buf_ready", lu_ready, 1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        sample();
        check("buf_pending1", lu_pending, 1);
        check("buf_drain_we", rf_we, 1);
        check("buf_drain_waddr", rf_waddr, 3);
        check("buf_drain_wdata", rf_wdata, 32'h11);
        tick();
        sample();
        check("buf_pending0", lu_pending, 0);
        check("buf_idle_we", rf_we, 0);
        tick();

        // Kill: buffered rd=9 overtaken by a pipe write to rd=9
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99);
        tick();
        drive(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0);
        sample();
        check("kill_waddr", rf_waddr, 9);
        check("kill_wdata", rf_wdata, 32'h77);
        check("kill_pending", lu_pending, 1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        sample();
        check("kill_pop_no_write", rf_we, 0);
        tick();
        sample();
        check("kill_pending0", lu_pending, 0);
        tick();

        // Same-cycle LU result to the pipe's rd is dropped; lu_rd=0 is dropped
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h60);
        sample();
        check("drop_ready", lu_ready, 1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5);
        sample();
        check("drop_pending", lu_pending, 0);
        check("rd0_ready", lu_ready, 1);
        check("rd0_we", rf_we, 0);
        tick();
        sample();
        check("rd0_pending", lu_pending, 0);

        // Full / starvation
        drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hAAAA);
        tick();
        drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd11, 32'hBBBB);
        tick();
        drive(1'b1, 5'd1, 32'h102, 1'b0, 5'd0, 32'h0);
        sample();
        check("full_pending", lu_pending, 2);
        check("full_ready", lu_ready, 0);
        tick();
        tick();
        sample();
        check("starve_not_yet", wb_stall_req, 0);
        tick();
        sample();
        check("starve_req", wb_stall_req, 1);
        check("starve_pipe_wins", rf_waddr, 1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        sample();
        check("bubble_we", rf_we, 1);
        check("bubble_waddr", rf_waddr, 10);
        check("bubble_wdata", rf_wdata, 32'hAAAA);
        check("bubble_stall_held", wb_stall_req, 1);
        check("bubble_ready", lu_ready, 1);
        tick();
        sample();
        check("starve_drop", wb_stall_req, 0);
        check("second_waddr", rf_waddr, 11);
        check("second_wdata", rf_wdata, 32'hBBBB);
        tick();
        sample();
        check("starve_empty", lu_pending, 0);
        check("starve_idle_we", rf_we, 0);

        // Pop + enqueue while full, then reset with two entries queued
        drive(1'b1, 5'd1, 32'h200, 1'b1, 5'd13, 32'hD13);
        tick();
        drive(1'b1, 5'd1, 32'h201, 1'b1, 5'd14, 32'hD14);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'hD15);
        sample();
        check("popenq_ready", lu_ready, 1);
        check("popenq_waddr", rf_waddr, 13);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        sample();
        check("popenq_pending", lu_pending, 2);
        check("rst_mid_we", rf_we, 0);
        check("rst_mid_ready", lu_ready, 0);
        tick();
        reset = 1'b0;
        sample();
        check("rst_mid_pending", lu_pending, 0);
        check("rst_mid_stall", wb_stall_req, 0);
        check("rst_release_we", rf_we, 0);
        tick();
        sample();
        check("rst_no_stale_we", rf_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
